// File: rtl/alu_src_mux_pipe_pkg.sv
// Shared definitions for the ALU operand-select pipeline stage:
// default geometry and the skid-buffer state encoding.
package alu_src_mux_pipe_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NUM_IN = 4;
   localparam int DEF_SEL_W  = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/alu_src_mux_pipe_if.sv
// Operand-select bus: upstream source/select handshake, downstream operand
// handshake, squash and sticky error. The slave modport is the pipeline stage.
interface alu_src_mux_pipe_if
   import alu_src_mux_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = DEF_SEL_W
);

   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic [WIDTH-1:0]        out_data;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;
   logic                    err_sticky;

   modport master (
      output in_data, in_sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_err, out_valid, err_sticky
   );

   modport slave (
      input  in_data, in_sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_err, out_valid, err_sticky
   );

endinterface

// File: rtl/alu_src_mux_pipe_sel.sv
// Combinational NUM_IN-way operand selector; unused select codes yield a
// zero word with the error flag raised.
module alu_src_sel
   import alu_src_mux_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic [NUM_IN*WIDTH-1:0] data,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        word,
   output logic                    err
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      word = '0;
      err  = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i)) begin
            word = data[i*WIDTH +: WIDTH];
            err  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_src_mux_pipe.sv
// ALU operand-select stage: picks one of NUM_IN sources and holds the result
// in a 2-entry skid buffer with a registered in_ready and synchronous flush.
module alu_src_mux_pipe
   import alu_src_mux_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = DEF_SEL_W
) (
   input logic               clk,
   input logic               rst_n,
   alu_src_mux_pipe_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic             main_err_q, main_err_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_err_q, skid_err_d;
   logic             in_ready_q, in_ready_d;
   logic             sticky_q, sticky_d;

   logic [WIDTH-1:0] sel_word;
   logic             sel_err;
   logic             in_fire;
   logic             out_fire;
   logic             out_valid;

   alu_src_sel #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_sel (
      .data (bus.in_data),
      .sel  (bus.in_sel),
      .word (sel_word),
      .err  (sel_err)
   );

   assign out_valid = (state_q != EMPTY);
   assign in_fire   = bus.in_valid & in_ready_q;
   assign out_fire  = out_valid & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_err_d  = main_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
      sticky_d    = sticky_q;

      if (bus.flush) begin
         // Squash wins over everything; an incoming word is simply dropped.
         state_d  = EMPTY;
         sticky_d = 1'b0;
      end else begin
         if (in_fire && sel_err)
            sticky_d = 1'b1;

         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d     = ONE;
                  main_data_d = sel_word;
                  main_err_d  = sel_err;
               end
            end
            ONE: begin
               if (in_fire && !out_fire) begin
                  state_d     = TWO;
                  skid_data_d = sel_word;
                  skid_err_d  = sel_err;
               end else if (!in_fire && out_fire) begin
                  state_d = EMPTY;
               end else if (in_fire && out_fire) begin
                  main_data_d = sel_word;
                  main_err_d  = sel_err;
               end
            end
            TWO: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_d     = ONE;
                  main_data_d = skid_data_q;
                  main_err_d  = skid_err_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      // Ready is a function of the next state only, keeping out_ready off
      // any combinational path to in_ready.
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_err_q  <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_err_q  <= main_err_d;
         skid_data_q <= skid_data_d;
         skid_err_q  <= skid_err_d;
         in_ready_q  <= in_ready_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid;
   assign bus.out_data   = main_data_q;
   assign bus.out_err    = main_err_q;
   assign bus.err_sticky = sticky_q;

endmodule
